// File: rtl/key_encoder.sv
// Debounced 4-symbol + undo keypad encoder driving a push/pop symbol stack.
// Each accepted press produces exactly one registered PUSH, POP or REJECT strobe.
module key_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] BTN,
  input  logic       UNDO,
  input  logic       FULL,
  input  logic       EMPTY,
  output logic       PUSH,
  output logic       POP,
  output logic [1:0] DATA_OUT,
  output logic       REJECT
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    FIRE    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       cand_q;
  logic [4:0]       sync1_q;
  logic [4:0]       sync2_q;
  logic             push_q;
  logic             pop_q;
  logic             reject_q;
  logic [1:0]       data_q;

  logic       btn_only_d;
  logic       undo_only_d;
  logic       push_d;
  logic       pop_d;
  logic       reject_d;
  logic [1:0] btn_idx_d;

  // Classify the settled candidate; evaluated against FULL/EMPTY at the FIRE-entry edge.
  always_comb begin
    btn_only_d  = ($countones(cand_q) == 1) && !cand_q[4];
    undo_only_d = (cand_q == 5'b10000);
    push_d      = btn_only_d && !FULL;
    pop_d       = undo_only_d && !EMPTY;
    reject_d    = !(push_d || pop_d);
    btn_idx_d   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (cand_q[i]) btn_idx_d = 2'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      reject_q <= 1'b0;
      data_q   <= 2'd0;
    end else begin
      sync1_q  <= {UNDO, BTN};
      sync2_q  <= sync1_q;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      reject_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sync2_q != 5'd0) begin
            cand_q  <= sync2_q;
            cnt_q   <= '0;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (sync2_q != cand_q) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            state_q  <= FIRE;
            push_q   <= push_d;
            pop_q    <= pop_d;
            reject_q <= reject_d;
            if (push_d) data_q <= btn_idx_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        FIRE: begin
          // Input changes here are deliberately left for HOLD to see.
          cnt_q   <= '0;
          state_q <= HOLD;
        end
        HOLD: begin
          if (sync2_q == 5'd0) begin
            cnt_q   <= '0;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (sync2_q != 5'd0) begin
            cnt_q   <= '0;
            state_q <= HOLD;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign PUSH     = push_q;
  assign POP      = pop_q;
  assign REJECT   = reject_q;
  assign DATA_OUT = data_q;

endmodule

// File: doc/key_encoder.md
KEY_ENCODER -- requirements
Module: key_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: input-stable cycles required before a press or release is accepted; legal range 1..65535.
REQ-002 Debounce counter width SHALL be clog2(DEBOUNCE_CYCLES+1), computed with the shared clog2 function include.
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 BTN  input  4  raw asynchronous symbol buttons, active-high; BTN[i] encodes symbol i.
REQ-006 UNDO  input  1  raw asynchronous undo button, active-high.
REQ-007 FULL  input  1  downstream stack full flag.
REQ-008 EMPTY  input  1  downstream stack empty flag.
REQ-009 PUSH  output  1  registered one-cycle push strobe to the stack.
REQ-010 POP  output  1  registered one-cycle pop strobe to the stack.
REQ-011 DATA_OUT  output  2  registered symbol for the stack DATA_IN.
REQ-012 REJECT  output  1  registered one-cycle strobe for a dropped request.

Function
REQ-013 Each of the 5 raw inputs SHALL pass through a 2-flop synchronizer; the synchronized vector is S = {UNDO, BTN}.
REQ-014 FSM states SHALL be IDLE, SETTLE, FIRE, HOLD and RELEASE; the counter SHALL clear on every state change.
REQ-015 IDLE: if S == 0, stay in IDLE; otherwise latch S into the candidate register CAND and go to SETTLE.
REQ-016 SETTLE: if S != CAND, go to IDLE (treated as bounce, no output); if count == DEBOUNCE_CYCLES-1, go to FIRE; otherwise increment count.
REQ-017 FIRE lasts exactly one cycle and always goes to HOLD.
REQ-018 HOLD: if S == 0, go to RELEASE; otherwise stay in HOLD, so a held button never repeats.
REQ-019 RELEASE: if S != 0, go back to HOLD; if count == DEBOUNCE_CYCLES-1, go to IDLE; otherwise increment count.
REQ-020 Outputs SHALL be set on the edge that enters FIRE, using FULL and EMPTY sampled at that same edge.
REQ-021 PUSH, POP and REJECT SHALL be high only during the FIRE cycle, and at most one of them SHALL be high.
REQ-022 CAND with exactly one BTN[i] set and FULL = 0 SHALL give PUSH = 1 and DATA_OUT = i.
REQ-023 CAND with exactly one BTN[i] set and FULL = 1 SHALL give REJECT = 1, with DATA_OUT unchanged.
REQ-024 CAND == UNDO only SHALL give POP = 1 if EMPTY = 0, else REJECT = 1.
REQ-025 Any CAND with two or more bits set SHALL give REJECT = 1 and no PUSH or POP.
REQ-026 DATA_OUT SHALL hold the last pushed symbol and change only on an accepted push.
REQ-027 Latency: for stable input, the strobe SHALL be high in the cycle after the (DEBOUNCE_CYCLES+3)th rising edge that samples the raw input high.
REQ-028 The count SHALL never exceed DEBOUNCE_CYCLES-1, so it has no wrap-around.
REQ-029 With DEBOUNCE_CYCLES = 1, SETTLE and RELEASE SHALL each last one cycle.
REQ-030 A change in S during FIRE SHALL be ignored; it is evaluated in HOLD.

Reset
REQ-031 When RST = 1 at an edge, the block SHALL set state = IDLE, counter = 0, CAND = 0, synchronizers = 0, PUSH = POP = REJECT = 0 and DATA_OUT = 0, from any state.
REQ-032 Reset mid-operation SHALL discard any pending press; no strobe appears for it.
REQ-033 A button held through reset release SHALL be debounced as a new press.

Verification (DEBOUNCE_CYCLES = 4)
REQ-034 BTN = 4'b0100 held 20 cycles, FULL = 0 -> one PUSH pulse after the 7th edge, DATA_OUT = 2, no further pulses.
REQ-035 BTN[0] toggled every 2 cycles for 12 cycles, then held -> no strobe during toggling; one PUSH with DATA_OUT = 0 after settle.
REQ-036 BTN = 4'b1000 with FULL = 1 -> REJECT pulse, PUSH = 0, DATA_OUT keeps its prior value; UNDO with EMPTY = 1 -> REJECT; UNDO with EMPTY = 0 -> POP.
REQ-037 BTN = 4'b0011 pressed together -> one REJECT pulse, no PUSH.
REQ-038 Press, release for 2 cycles, press again -> release not accepted, so one PUSH only; a release of 6 or more cycles followed by a press -> second PUSH.
REQ-039 RST asserted in SETTLE with BTN held -> all outputs 0; after RST drops, one PUSH 7 edges later.
